// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch front end: reset PC,
// fetch state encodings and the {pc, inst} entry handed to decode.
package inst_fetch_queue_pkg;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  // One fetched instruction with the PC the interface reported for it.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Sequential fetch address; wraps at 32 bits with no carry out.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// Small FIFO of fetched entries. Flush empties it in one edge and wins
// over any push or pop in the same cycle. The head is read combinationally
// and forced to zero while empty so decode never sees stale storage.
module fetch_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output logic         full,
  output logic         head_valid,
  output fetch_entry_t head_entry
);

  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W:0]   count_reg, count_next;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO cannot happen with one request outstanding;
  // the full guard only keeps the pointers sane if that ever breaks.
  assign do_push = push && !flush && (count_reg != FULL_COUNT);
  assign do_pop  = pop && !flush && (count_reg != '0);

  assign full       = (count_reg == FULL_COUNT);
  assign head_valid = (count_reg != '0);
  assign head_entry = head_valid ? mem[rd_ptr_reg] : '0;

  // Next pointers and occupancy; simultaneous push and pop keep count.
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (do_push) wr_ptr_next = wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_next = rd_ptr_reg + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_next = count_reg + CNT_ONE;
        2'b01:   count_next = count_reg - CNT_ONE;
        default: count_next = count_reg;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Entry storage; contents need no reset because occupancy gates the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_entry;
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: issues sequential PCs to the instruction interface one
// request at a time, queues the returned words for decode, and flushes on
// redirect while draining any response that is already in flight.
module inst_fetch_queue
  import inst_fetch_queue_pkg::fetch_state_e,
         inst_fetch_queue_pkg::fetch_entry_t,
         inst_fetch_queue_pkg::IDLE,
         inst_fetch_queue_pkg::REQ,
         inst_fetch_queue_pkg::DROP,
         inst_fetch_queue_pkg::next_seq_pc;
#(
  parameter logic [31:0] RESET_PC = inst_fetch_queue_pkg::RESET_PC,
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        fetch_enable,
  output logic [31:0] fetch_pc,
  input  logic [31:0] fetch_resp_pc,
  input  logic [31:0] fetch_inst,
  input  logic        fetch_wait,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  input  logic        id_ready
);

  fetch_state_e state_reg, state_next;
  logic [31:0]  next_pc_reg, next_pc_next;
  logic [31:0]  fetch_pc_reg, fetch_pc_next;
  logic         fetch_enable_reg, fetch_enable_next;
  logic         push;
  logic         fifo_full;
  logic         head_valid;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  assign push_entry.pc   = fetch_resp_pc;
  assign push_entry.inst = fetch_inst;

  assign fetch_enable = fetch_enable_reg;
  assign fetch_pc     = fetch_pc_reg;
  assign id_valid     = head_valid;
  assign id_pc        = head_entry.pc;
  assign id_inst      = head_entry.inst;

  // Fetch sequencing: issue only with room in the FIFO, so a response always
  // has a slot; a redirect reloads the PC and turns a live request into a drop.
  always_comb begin
    state_next        = state_reg;
    next_pc_next      = next_pc_reg;
    fetch_pc_next     = fetch_pc_reg;
    fetch_enable_next = fetch_enable_reg;
    push              = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!redirect_valid && !fifo_full) begin
          fetch_enable_next = 1'b1;
          fetch_pc_next     = next_pc_reg;
          next_pc_next      = next_seq_pc(next_pc_reg);
          state_next        = REQ;
        end
      end
      REQ: begin
        if (!fetch_wait) begin
          push              = !redirect_valid;
          fetch_enable_next = 1'b0;
          state_next        = IDLE;
        end else if (redirect_valid) begin
          state_next = DROP;
        end
      end
      DROP: begin
        if (!fetch_wait) begin
          fetch_enable_next = 1'b0;
          state_next        = IDLE;
        end
      end
      default: begin
        fetch_enable_next = 1'b0;
        state_next        = IDLE;
      end
    endcase

    // The new target is taken unchanged, even if misaligned.
    if (redirect_valid) begin
      next_pc_next = redirect_pc;
    end
  end

  // Fetch state, PC and interface request registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      next_pc_reg      <= RESET_PC;
      fetch_pc_reg     <= RESET_PC;
      fetch_enable_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      next_pc_reg      <= next_pc_next;
      fetch_pc_reg     <= fetch_pc_next;
      fetch_enable_reg <= fetch_enable_next;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (id_ready),
    .full       (fifo_full),
    .head_valid (head_valid),
    .head_entry (head_entry)
  );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: a per-cycle vector table for the
// basic fetch/decode flow, then hand-written sequences for backpressure,
// redirects, push/pop overlap and asynchronous reset.
module tb_inst_fetch_queue;

  localparam logic [31:0] B = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_enable;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_resp_pc;
  logic [31:0] fetch_inst;
  logic        fetch_wait;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready;

  // Interface model controls: manual wait from the test, or auto latency.
  logic auto_mode = 1'b0;
  logic hold      = 1'b0;
  logic tb_wait   = 1'b1;
  logic auto_wait = 1'b1;
  int   lat       = 2;
  int   auto_cnt  = 0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // The interface returns the word for the address it was asked for.
  assign fetch_resp_pc = fetch_pc;
  assign fetch_inst    = inst_of(fetch_pc);
  assign fetch_wait    = auto_mode ? auto_wait : tb_wait;

  always @(negedge clk) begin
    if (!fetch_enable || !reset) begin
      auto_cnt  <= 0;
      auto_wait <= 1'b1;
    end else if (hold) begin
      auto_wait <= 1'b1;
    end else if (auto_cnt >= lat) begin
      auto_wait <= 1'b0;
      auto_cnt  <= 0;
    end else begin
      auto_wait <= 1'b1;
      auto_cnt  <= auto_cnt + 1;
    end
  end

  inst_fetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_enable   (fetch_enable),
    .fetch_pc       (fetch_pc),
    .fetch_resp_pc  (fetch_resp_pc),
    .fetch_inst     (fetch_inst),
    .fetch_wait     (fetch_wait),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_inst        (id_inst),
    .id_ready       (id_ready)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // One clock edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic use_auto);
    reset          = 1'b0;
    auto_mode      = use_auto;
    hold           = 1'b0;
    tb_wait        = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
  endtask

  // Wait for a head entry, check it, then consume it with a one-cycle ready.
  task automatic pop_check(input string name, input logic [31:0] exp_pc);
    for (int i = 0; i < 40 && !id_valid; i++) step();
    check1({name, "_valid"}, id_valid, 1'b1);
    check32({name, "_pc"}, id_pc, exp_pc);
    check32({name, "_inst"}, id_inst, inst_of(exp_pc));
    $display("pop %s: id_pc=%h id_inst=%h", name, id_pc, id_inst);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
  endtask

  typedef struct {
    logic        wt;
    logic        rdy;
    logic        en;
    logic [31:0] pc;
    logic        v;
    logic [31:0] idpc;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // Sequential fetch with decode always ready: wait, wait, respond.
    vecs[0] = '{1'b1, 1'b1, 1'b1, B,          1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, B,          1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, B,          1'b1, B};
    vecs[3] = '{1'b1, 1'b1, 1'b1, B + 32'h4,  1'b0, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, B + 32'h4,  1'b0, 32'h0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, B + 32'h4,  1'b1, B + 32'h4};
    vecs[6] = '{1'b1, 1'b1, 1'b1, B + 32'h8,  1'b0, 32'h0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, B + 32'h8,  1'b0, 32'h0};
    vecs[8] = '{1'b0, 1'b1, 1'b0, B + 32'h8,  1'b1, B + 32'h8};
    vecs[9] = '{1'b1, 1'b0, 1'b1, B + 32'hC,  1'b1, B + 32'h8};

    // Reset values while reset is held.
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b0;
    #1 reset = 1'b0;
    #2;
    check1("rst_en", fetch_enable, 1'b0);
    check32("rst_fetch_pc", fetch_pc, B);
    check1("rst_id_valid", id_valid, 1'b0);
    check32("rst_id_pc", id_pc, 32'h0);
    check32("rst_id_inst", id_inst, 32'h0);

    // Table-driven sequential fetch.
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      tb_wait  = vecs[i].wt;
      id_ready = vecs[i].rdy;
      step();
      $display("vec %0d: en=%b fetch_pc=%h id_valid=%b id_pc=%h", i, fetch_enable, fetch_pc, id_valid, id_pc);
      check1($sformatf("vec%0d_en", i), fetch_enable, vecs[i].en);
      check32($sformatf("vec%0d_fetch_pc", i), fetch_pc, vecs[i].pc);
      check1($sformatf("vec%0d_id_valid", i), id_valid, vecs[i].v);
      if (vecs[i].v) begin
        check32($sformatf("vec%0d_id_pc", i), id_pc, vecs[i].idpc);
        check32($sformatf("vec%0d_id_inst", i), id_inst, inst_of(vecs[i].idpc));
      end
    end

    // Backpressure: decode never ready, FIFO fills to 4 and issue stops.
    do_reset(1'b1);
    repeat (30) step();
    $display("full: en=%b fetch_pc=%h id_pc=%h", fetch_enable, fetch_pc, id_pc);
    check1("full_en", fetch_enable, 1'b0);
    check32("full_last_pc", fetch_pc, B + 32'hC);
    check32("full_head", id_pc, B);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    check32("full_pop_head", id_pc, B + 32'h4);
    check1("full_pop_no_issue", fetch_enable, 1'b0);
    step();
    check1("full_reissue_en", fetch_enable, 1'b1);
    check32("full_reissue_pc", fetch_pc, B + 32'h10);
    pop_check("bp0", B + 32'h4);
    pop_check("bp1", B + 32'h8);
    pop_check("bp2", B + 32'hC);
    pop_check("bp3", B + 32'h10);
    pop_check("bp4", B + 32'h14);

    // Redirect while a request is stalled: response dropped, restart at target.
    do_reset(1'b1);
    for (int i = 0; i < 40 && !(id_valid && fetch_enable); i++) step();
    check1("drop_setup", id_valid && fetch_enable, 1'b1);
    hold = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    step();
    redirect_valid = 1'b0;
    check1("drop_flush_valid", id_valid, 1'b0);
    check1("drop_en_held", fetch_enable, 1'b1);
    check32("drop_pc_held", fetch_pc, B + 32'h4);
    step();
    check1("drop_still_en", fetch_enable, 1'b1);
    hold = 1'b0;
    for (int i = 0; i < 20 && fetch_enable; i++) step();
    check1("drop_done", fetch_enable, 1'b0);
    check1("drop_not_pushed", id_valid, 1'b0);
    for (int i = 0; i < 20 && !fetch_enable; i++) step();
    check1("drop_new_en", fetch_enable, 1'b1);
    check32("drop_new_pc", fetch_pc, 32'h8000_0100);
    check1("drop_empty_at_issue", id_valid, 1'b0);
    pop_check("drop_first", 32'h8000_0100);

    // Redirect colliding with a response and a pop while count is 2.
    do_reset(1'b0);
    tb_wait = 1'b1; step();
    tb_wait = 1'b0; step();
    tb_wait = 1'b1; step();
    tb_wait = 1'b0; step();
    tb_wait = 1'b1; step();
    check32("coll_head", id_pc, B);
    check32("coll_req_pc", fetch_pc, B + 32'h8);
    tb_wait        = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2000;
    id_ready       = 1'b1;
    step();
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    tb_wait        = 1'b1;
    check1("coll_flush_valid", id_valid, 1'b0);
    check1("coll_idle", fetch_enable, 1'b0);
    step();
    check1("coll_new_en", fetch_enable, 1'b1);
    check32("coll_new_pc", fetch_pc, 32'h0000_2000);
    check1("coll_no_push", id_valid, 1'b0);
    tb_wait = 1'b0;
    step();
    tb_wait = 1'b1;
    check1("coll_push_valid", id_valid, 1'b1);
    check32("coll_push_pc", id_pc, 32'h0000_2000);
    check32("coll_push_inst", id_inst, inst_of(32'h0000_2000));

    // Push and pop together with 3 queued, then fill to 4 and drain in order.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      tb_wait = 1'b1; step();
      tb_wait = 1'b0; step();
    end
    tb_wait = 1'b1; step();
    check32("pp_req_pc", fetch_pc, B + 32'hC);
    tb_wait  = 1'b0;
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    tb_wait  = 1'b1;
    check32("pp_head", id_pc, B + 32'h4);
    check1("pp_en", fetch_enable, 1'b0);
    step();
    check1("pp_issue_en", fetch_enable, 1'b1);
    check32("pp_issue_pc", fetch_pc, B + 32'h10);
    tb_wait = 1'b0; step();
    tb_wait = 1'b1; step();
    check1("pp_full_no_issue", fetch_enable, 1'b0);
    step();
    check1("pp_full_no_issue2", fetch_enable, 1'b0);
    check32("pp_full_pc_hold", fetch_pc, B + 32'h10);
    id_ready = 1'b1;
    step();
    check32("pp_drain0", id_pc, B + 32'h8);
    check1("pp_drain0_en", fetch_enable, 1'b0);
    step();
    check32("pp_drain1", id_pc, B + 32'hC);
    check32("pp_drain1_issue", fetch_pc, B + 32'h14);
    step();
    check32("pp_drain2", id_pc, B + 32'h10);
    check32("pp_drain2_inst", id_inst, inst_of(B + 32'h10));
    step();
    check1("pp_drained", id_valid, 1'b0);
    id_ready = 1'b0;

    // Asynchronous reset in the middle of a request.
    do_reset(1'b0);
    tb_wait = 1'b1; step();
    tb_wait = 1'b0; step();
    tb_wait = 1'b1; step();
    check1("ar_pre_en", fetch_enable, 1'b1);
    #2 reset = 1'b0;
    #1;
    check1("ar_en", fetch_enable, 1'b0);
    check32("ar_fetch_pc", fetch_pc, B);
    check1("ar_id_valid", id_valid, 1'b0);
    check32("ar_id_pc", id_pc, 32'h0);
    check32("ar_id_inst", id_inst, 32'h0);
    #5 reset = 1'b1;
    step();
    check1("ar_restart_en", fetch_enable, 1'b1);
    check32("ar_restart_pc", fetch_pc, B);
    check1("ar_restart_empty", id_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
